uart_tx_cfg: RTL and testbench

Parametrised UART transmitter and successor to the fixed 8N1 transmitter. It serialises one DATA_BITS word per frame, LSB first, with an optional parity bit and 1 or 2 stop bits. Bit timing comes from an internal, phase-aligned oversampling tick. It sits between the packet/response formatter (valid/ready source) and the board TX pin.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_cfg_if.sv | 15 +
 rtl/uart_tx_cfg_tick_gen.sv | 34 +++
 rtl/uart_tx_cfg.sv | 176 +++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and defaults for the configurable UART transmitter.
//   uart_tx_state_t : transmitter FSM states
//   uart_parity_t   : parity mode encoding (matches the PARITY parameter values)
//   parity_of()     : parity bit of a latched word for a given mode
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;

   typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} uart_parity_t;

   localparam int unsigned CLKS_PER_TICK_DEF = 54;
   localparam int unsigned OVERSAMPLE_DEF    = 16;

   // Unused upper bits of narrower words must be zero so they do not disturb the XOR.
   function automatic logic parity_of(input logic [8:0] word, input uart_parity_t mode);
      return (^word) ^ (mode == PAR_ODD);
   endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// uart_tx_cfg_if: valid/ready word interface between the formatter and the transmitter.
//   s_data  : word to transmit (DATA_BITS wide)
//   s_valid : s_data valid, driven by the source
//   s_ready : transmitter can accept a word
//   master  : source side (formatter); slave : transmitter side
interface uart_tx_cfg_if #(
   parameter int unsigned DATA_BITS = 8
);
   logic [DATA_BITS-1:0] s_data;
   logic                 s_valid;
   logic                 s_ready;

   modport master (output s_data, output s_valid, input s_ready);
   modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/uart_tx_cfg_tick_gen.sv
// uart_tick_gen: oversample tick generator.
//   clk     : system clock
//   rst_n   : synchronous active-low reset
//   restart : zero the count so the next tick is CLKS_PER_TICK cycles away
//   tick    : one-cycle pulse on the terminal count
module uart_tick_gen #(
   parameter int unsigned CLKS_PER_TICK = uart_pkg::CLKS_PER_TICK_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   output logic tick
);
   localparam int unsigned CW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_TICK - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      tick  = (cnt_q == CNT_LAST);
      cnt_d = cnt_q + 1'b1;
      if (restart || tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter (DATA_BITS, parity, 1/2 stop bits).
//   clk     : system clock
//   rst_n   : synchronous active-low reset
//   s_if    : valid/ready word input (slave side)
//   tx      : registered serial line, idle high
//   busy    : frame in progress
//   tx_done : one-cycle pulse in the first idle cycle after a frame
//
// state  | meaning
// -------+-------------------------------------------------
// IDLE   | line high, s_ready asserted, waiting for a word
// START  | driving the start bit (0) for one bit period
// DATA   | shifting out data bits LSB first
// PARITY | driving the parity bit of the latched word
// STOP   | driving 1 for STOP_BITS bit periods
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_TICK = CLKS_PER_TICK_DEF,
   parameter int unsigned OVERSAMPLE    = OVERSAMPLE_DEF,
   parameter int unsigned DATA_BITS     = 8,
   parameter int unsigned PARITY        = 0,
   parameter int unsigned STOP_BITS     = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   uart_tx_cfg_if.slave  s_if,
   output logic          tx,
   output logic          busy,
   output logic          tx_done
);
   if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 ||
       (STOP_BITS != 1 && STOP_BITS != 2) || OVERSAMPLE < 2 || CLKS_PER_TICK < 1) begin : g_bad_params
      $error("uart_tx_cfg: illegal parameter set");
   end

   localparam int unsigned OW = $clog2(OVERSAMPLE);
   localparam int unsigned BW = $clog2(DATA_BITS + 1);
   localparam logic [OW-1:0] OS_LAST   = OW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
   localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
   localparam uart_parity_t  PAR_CFG   = uart_parity_t'(PARITY[1:0]);

   uart_tx_state_t       state_q, state_d;
   logic [OW-1:0]        os_q, os_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic                 stop_q, stop_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 tx_q, tx_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;

   logic tick;
   logic accept;
   logic bit_end;

   assign s_if.s_ready = (state_q == IDLE) && rst_n;
   assign accept       = s_if.s_valid && s_if.s_ready;
   assign bit_end      = tick && (os_q == OS_LAST);

   // Restarting on accept phase-aligns every bit period to the start bit.
   uart_tick_gen #(
      .CLKS_PER_TICK (CLKS_PER_TICK)
   ) u_tick_gen (
      .clk     (clk),
      .rst_n   (rst_n),
      .restart (accept),
      .tick    (tick)
   );

   always_comb begin
      state_d = state_q;
      os_d    = os_q;
      bit_d   = bit_q;
      stop_d  = stop_q;
      shift_d = shift_q;
      par_d   = par_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      if (state_q != IDLE && tick) begin
         os_d = (os_q == OS_LAST) ? '0 : os_q + 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = START;
               os_d    = '0;
               bit_d   = '0;
               stop_d  = 1'b0;
               shift_d = s_if.s_data;
               par_d   = parity_of(9'(s_if.s_data), PAR_CFG);
               tx_d    = 1'b0;
               busy_d  = 1'b1;
            end
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               tx_d    = shift_q[0];
               shift_d = shift_q >> 1;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_q == BIT_LAST) begin
                  if (PAR_CFG != PAR_NONE) begin
                     state_d = uart_pkg::PARITY;
                     tx_d    = par_q;
                  end else begin
                     state_d = STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_d   = bit_q + 1'b1;
                  tx_d    = shift_q[0];
                  shift_d = shift_q >> 1;
               end
            end
         end
         uart_pkg::PARITY: begin
            if (bit_end) begin
               state_d = STOP;
               tx_d    = 1'b1;
            end
         end
         STOP: begin
            if (bit_end) begin
               if (stop_q == STOP_LAST) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  stop_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         os_q    <= '0;
         bit_q   <= '0;
         stop_q  <= 1'b0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         os_q    <= os_d;
         bit_q   <= bit_d;
         stop_q  <= stop_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign tx      = tx_q;
   assign busy    = busy_q;
   assign tx_done = done_q;
endmodule

// File: tb/tb_uart_tx_cfg.sv
module tb_uart_tx_cfg;
   localparam int CPT = 2;
   localparam int OS  = 4;
   localparam int T   = CPT * OS;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Four configurations: 8N1, 8E1, 8O1, 7N2
   int db_c[4]   = '{8, 8, 8, 7};
   int par_c[4]  = '{0, 1, 2, 0};
   int stop_c[4] = '{1, 1, 1, 2};

   logic [8:0] data_a[4];
   logic       valid_a[4];
   logic       ready_w[4];
   logic       tx_w[4];
   logic       busy_w[4];
   logic       done_w[4];

   int n_cmp = 0;
   int n_bad = 0;

   uart_tx_cfg_if #(.DATA_BITS(8)) if0 ();
   uart_tx_cfg_if #(.DATA_BITS(8)) if1 ();
   uart_tx_cfg_if #(.DATA_BITS(8)) if2 ();
   uart_tx_cfg_if #(.DATA_BITS(7)) if3 ();

   assign if0.s_data = data_a[0][7:0];
   assign if1.s_data = data_a[1][7:0];
   assign if2.s_data = data_a[2][7:0];
   assign if3.s_data = data_a[3][6:0];
   assign if0.s_valid = valid_a[0];
   assign if1.s_valid = valid_a[1];
   assign if2.s_valid = valid_a[2];
   assign if3.s_valid = valid_a[3];
   assign ready_w[0] = if0.s_ready;
   assign ready_w[1] = if1.s_ready;
   assign ready_w[2] = if2.s_ready;
   assign ready_w[3] = if3.s_ready;

   uart_tx_cfg #(.CLKS_PER_TICK(CPT), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
      u0 (.clk(clk), .rst_n(rst_n), .s_if(if0), .tx(tx_w[0]), .busy(busy_w[0]), .tx_done(done_w[0]));
   uart_tx_cfg #(.CLKS_PER_TICK(CPT), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1))
      u1 (.clk(clk), .rst_n(rst_n), .s_if(if1), .tx(tx_w[1]), .busy(busy_w[1]), .tx_done(done_w[1]));
   uart_tx_cfg #(.CLKS_PER_TICK(CPT), .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
      u2 (.clk(clk), .rst_n(rst_n), .s_if(if2), .tx(tx_w[2]), .busy(busy_w[2]), .tx_done(done_w[2]));
   uart_tx_cfg #(.CLKS_PER_TICK(CPT), .OVERSAMPLE(OS), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2))
      u3 (.clk(clk), .rst_n(rst_n), .s_if(if3), .tx(tx_w[3]), .busy(busy_w[3]), .tx_done(done_w[3]));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int d, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s dut%0d: observed %b expected %b", tag, d, obs, exp);
      end
   endtask

   function automatic int frame_bits(input int d);
      return 1 + db_c[d] + ((par_c[d] != 0) ? 1 : 0) + stop_c[d];
   endfunction

   // Reference frame: list of line levels, one per bit period.
   function automatic logic model_bit(input int d, input logic [8:0] w, input int idx);
      logic q[$];
      int   ones;
      logic p;
      q.push_back(1'b0);
      ones = 0;
      for (int i = 0; i < db_c[d]; i++) begin
         q.push_back(w[i]);
         ones += int'(w[i]);
      end
      if (par_c[d] != 0) begin
         p = (ones % 2) == 1;
         if (par_c[d] == 2) p = ~p;
         q.push_back(p);
      end
      for (int i = 0; i < stop_c[d]; i++) q.push_back(1'b1);
      return q[idx];
   endfunction

   task automatic begin_frame(input int d, input logic [8:0] w);
      data_a[d]  = w;
      valid_a[d] = 1'b1;
      #1;
      chk("ready_before_accept", d, ready_w[d], 1'b1);
      tick();
   endtask

   // Entered in the first cycle after accept; ends one cycle after the tx_done
   // cycle, or in the first cycle of the next frame when hold keeps s_valid up.
   task automatic run_frame(input int d, input logic [8:0] w, input bit hold,
                            input logic [8:0] nxt, input bit dirty);
      int len;
      len = frame_bits(d) * T;
      if (hold) data_a[d] = nxt;
      else      valid_a[d] = 1'b0;
      for (int k = 1; k <= len; k++) begin
         if (dirty) begin
            data_a[d]  = 9'($urandom);
            valid_a[d] = (k < len) ? 1'($urandom_range(0, 1)) : 1'b0;
         end
         chk("tx_bit", d, tx_w[d], model_bit(d, w, (k - 1) / T));
         chk("busy_in_frame", d, busy_w[d], 1'b1);
         chk("ready_in_frame", d, ready_w[d], 1'b0);
         chk("done_in_frame", d, done_w[d], 1'b0);
         tick();
      end
      chk("done_pulse", d, done_w[d], 1'b1);
      chk("busy_after_frame", d, busy_w[d], 1'b0);
      chk("tx_idle_gap", d, tx_w[d], 1'b1);
      chk("ready_in_done", d, ready_w[d], 1'b1);
      tick();
      if (!hold) begin
         chk("done_one_cycle", d, done_w[d], 1'b0);
         chk("busy_idle", d, busy_w[d], 1'b0);
         chk("tx_idle", d, tx_w[d], 1'b1);
      end
   endtask

   initial begin
      logic [8:0] w;
      for (int d = 0; d < 4; d++) begin
         data_a[d]  = '0;
         valid_a[d] = 1'b0;
      end
      rst_n = 1'b0;
      tick();
      tick();
      for (int d = 0; d < 4; d++) begin
         chk("reset_tx", d, tx_w[d], 1'b1);
         chk("reset_busy", d, busy_w[d], 1'b0);
         chk("reset_done", d, done_w[d], 1'b0);
         chk("reset_ready", d, ready_w[d], 1'b0);
      end
      rst_n = 1'b1;
      #1;
      for (int d = 0; d < 4; d++) chk("ready_after_release", d, ready_w[d], 1'b1);
      tick();

      // Directed frames per configuration
      begin_frame(0, 9'h0A5); run_frame(0, 9'h0A5, 1'b0, 9'h0, 1'b0);
      begin_frame(1, 9'h0A5); run_frame(1, 9'h0A5, 1'b0, 9'h0, 1'b0);
      begin_frame(2, 9'h0A5); run_frame(2, 9'h0A5, 1'b0, 9'h0, 1'b0);
      begin_frame(3, 9'h041); run_frame(3, 9'h041, 1'b0, 9'h0, 1'b0);

      // Back-to-back with s_valid held high
      begin_frame(0, 9'h055);
      run_frame(0, 9'h055, 1'b1, 9'h00F, 1'b0);
      run_frame(0, 9'h00F, 1'b0, 9'h0, 1'b0);

      // Reset for one clock in the middle of a frame
      begin_frame(0, 9'h0A5);
      valid_a[0] = 1'b0;
      for (int k = 1; k < 30; k++) begin
         chk("tx_before_abort", 0, tx_w[0], model_bit(0, 9'h0A5, (k - 1) / T));
         tick();
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      chk("abort_tx", 0, tx_w[0], 1'b1);
      chk("abort_busy", 0, busy_w[0], 1'b0);
      chk("abort_done", 0, done_w[0], 1'b0);
      chk("abort_ready", 0, ready_w[0], 1'b1);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("abort_no_done", 0, done_w[0], 1'b0);
         chk("abort_tx_high", 0, tx_w[0], 1'b1);
      end
      begin_frame(0, 9'h03C); run_frame(0, 9'h03C, 1'b0, 9'h0, 1'b0);

      // s_valid pulses and s_data churn during frames
      begin_frame(0, 9'h096); run_frame(0, 9'h096, 1'b0, 9'h0, 1'b1);
      begin_frame(2, 9'h0C3); run_frame(2, 9'h0C3, 1'b0, 9'h0, 1'b1);
      begin_frame(3, 9'h02A); run_frame(3, 9'h02A, 1'b0, 9'h0, 1'b1);

      // Random words on every configuration, random idle gaps
      for (int d = 0; d < 4; d++) begin
         for (int n = 0; n < 3; n++) begin
            w = 9'($urandom) & ((9'h001 << db_c[d]) - 9'h001);
            begin_frame(d, w);
            run_frame(d, w, 1'b0, 9'h0, (n == 2));
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
